// File: rtl/xgmii_tx_framer_if.sv
// rtl/xgmii_tx_framer_if.sv - 64-bit frame stream into the XGMII transmit framer
interface xgmii_tx_framer_if;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic [2:0]  tx_nbytes;
    logic        tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        output tx_nbytes,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        input  tx_nbytes,
        output tx_ready
    );
endinterface

// File: rtl/xgmii_tx_framer.sv
// rtl/xgmii_tx_framer.sv - frame stream to XGMII TXD/TXC with start, terminate, IFG and underrun abort
// Optional frame/underrun counters are built when XGMII_TX_STATS_EN is defined.
module xgmii_tx_framer #(
    parameter int unsigned IFG_WORDS = 1
) (
    input  logic               mgt_clk,
    input  logic               reset_n,
    xgmii_tx_framer_if.slave   tx,
    input  logic               link_up,
    output logic [63:0]        xgmii_txd,
    output logic [7:0]         xgmii_txc,
    output logic               tx_underrun,
    output logic [31:0]        frame_count,
    output logic [31:0]        underrun_count
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_TERM = 3'd3;
    localparam logic [2:0] ST_IFG  = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;

    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_WORD   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [3:0]  IFG_LOAD   = 4'(IFG_WORDS);

    logic [2:0]  state_q, state_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        underrun_q, underrun_d;
    logic [3:0]  ifg_cnt_q, ifg_cnt_d;
    logic        aborted_q, aborted_d;
    logic        term_ok;
    logic [2:0]  after_term;
    logic [3:0]  nb;

    assign tx.tx_ready = (state_q == ST_DATA) || (state_q == ST_DROP);
    assign nb          = {1'b0, tx.tx_nbytes};

    // With no gap configured the terminate word leads straight to the next decision.
    always_comb begin
        after_term = ST_IFG;
        if (IFG_WORDS == 0) begin
            after_term = aborted_q ? ST_DROP : ST_IDLE;
        end
    end

    always_comb begin
        state_d    = state_q;
        txd_d      = IDLE_WORD;
        txc_d      = 8'hFF;
        underrun_d = 1'b0;
        ifg_cnt_d  = ifg_cnt_q;
        aborted_d  = aborted_q;
        term_ok    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx.tx_valid && link_up) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                txd_d   = START_WORD;
                txc_d   = 8'h01;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!tx.tx_valid) begin
                    txd_d      = ERR_WORD;
                    underrun_d = 1'b1;
                    aborted_d  = 1'b1;
                    state_d    = ST_TERM;
                end else if (!tx.tx_last) begin
                    txd_d = tx.tx_data;
                    txc_d = 8'h00;
                end else if (tx.tx_nbytes == 3'd7) begin
                    txd_d   = tx.tx_data;
                    txc_d   = 8'h00;
                    state_d = ST_TERM;
                end else begin
                    // Partial last word: terminate rides in the lane after the final data byte.
                    for (int k = 0; k < 8; k++) begin
                        if (4'(k) <= nb) begin
                            txd_d[8*k +: 8] = tx.tx_data[8*k +: 8];
                        end else if (4'(k) == nb + 4'd1) begin
                            txd_d[8*k +: 8] = 8'hFD;
                        end
                    end
                    txc_d     = 8'hFF << (nb + 4'd1);
                    term_ok   = 1'b1;
                    state_d   = after_term;
                    ifg_cnt_d = IFG_LOAD;
                end
            end
            ST_TERM: begin
                txd_d     = TERM_WORD;
                term_ok   = !aborted_q;
                state_d   = after_term;
                ifg_cnt_d = IFG_LOAD;
            end
            ST_IFG: begin
                if (ifg_cnt_q <= 4'd1) begin
                    ifg_cnt_d = 4'd0;
                    state_d   = aborted_q ? ST_DROP : ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - 4'd1;
                end
            end
            ST_DROP: begin
                if (tx.tx_valid && tx.tx_last) begin
                    aborted_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            txd_q      <= IDLE_WORD;
            txc_q      <= 8'hFF;
            underrun_q <= 1'b0;
            ifg_cnt_q  <= 4'd0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            txc_q      <= txc_d;
            underrun_q <= underrun_d;
            ifg_cnt_q  <= ifg_cnt_d;
            aborted_q  <= aborted_d;
        end
    end

    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign tx_underrun = underrun_q;

`ifdef XGMII_TX_STATS_EN
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        frame_cnt_d    = frame_cnt_q + {31'd0, term_ok};
        underrun_cnt_d = underrun_cnt_q + {31'd0, underrun_d};
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q    <= 32'd0;
            underrun_cnt_q <= 32'd0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign frame_count    = frame_cnt_q;
    assign underrun_count = underrun_cnt_q;
`else
    assign frame_count    = 32'd0;
    assign underrun_count = 32'd0;
`endif

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// tb/tb_xgmii_tx_framer.sv - directed bench for xgmii_tx_framer (IFG_WORDS=1 and IFG_WORDS=3 instances)
module tb_xgmii_tx_framer;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

`ifdef XGMII_TX_STATS_EN
    localparam logic [31:0] EXP_FRAMES    = 32'd2;
    localparam logic [31:0] EXP_UNDERRUNS = 32'd1;
`else
    localparam logic [31:0] EXP_FRAMES    = 32'd0;
    localparam logic [31:0] EXP_UNDERRUNS = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        link_up;
    logic [63:0] txd, txd3;
    logic [7:0]  txc, txc3;
    logic        und, und3;
    logic [31:0] fcnt, ucnt, fcnt3, ucnt3;
    int          total;
    int          bad;

    xgmii_tx_framer_if bus ();
    xgmii_tx_framer_if bus3 ();

    xgmii_tx_framer #(.IFG_WORDS(1)) dut (
        .mgt_clk        (clk),
        .reset_n        (rst_n),
        .tx             (bus.slave),
        .link_up        (link_up),
        .xgmii_txd      (txd),
        .xgmii_txc      (txc),
        .tx_underrun    (und),
        .frame_count    (fcnt),
        .underrun_count (ucnt)
    );

    xgmii_tx_framer #(.IFG_WORDS(3)) dut3 (
        .mgt_clk        (clk),
        .reset_n        (rst_n),
        .tx             (bus3.slave),
        .link_up        (link_up),
        .xgmii_txd      (txd3),
        .xgmii_txc      (txc3),
        .tx_underrun    (und3),
        .frame_count    (fcnt3),
        .underrun_count (ucnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] d, input logic [7:0] c);
        chk({tag, ".txd"}, txd, d);
        chk({tag, ".txc"}, {56'd0, txc}, {56'd0, c});
    endtask

    task automatic chk_out3(input string tag, input logic [63:0] d, input logic [7:0] c);
        chk({tag, ".txd"}, txd3, d);
        chk({tag, ".txc"}, {56'd0, txc3}, {56'd0, c});
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic [2:0] n);
        bus.tx_valid  = v;
        bus.tx_data   = d;
        bus.tx_last   = l;
        bus.tx_nbytes = n;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n   = 1'b0;
        link_up = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        bus3.tx_valid  = 1'b0;
        bus3.tx_data   = 64'd0;
        bus3.tx_last   = 1'b0;
        bus3.tx_nbytes = 3'd0;

        // Reset state
        tick();
        chk_out("reset", IDLE_W, 8'hFF);
        chk("reset.ready", {63'd0, bus.tx_ready}, 64'd0);
        chk("reset.underrun", {63'd0, und}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("idle", IDLE_W, 8'hFF);
            chk("idle.ready", {63'd0, bus.tx_ready}, 64'd0);
        end

        // One-word frame, 3 bytes
        drive(1'b1, 64'h0011223344556677, 1'b1, 3'd2);
        tick();
        chk_out("f1.pre", IDLE_W, 8'hFF);
        tick();
        chk_out("f1.start", START_W, 8'h01);
        chk("f1.ready", {63'd0, bus.tx_ready}, 64'd1);
        tick();
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        chk_out("f1.term", 64'h07070707FD556677, 8'hF8);
        tick();
        chk_out("f1.ifg", IDLE_W, 8'hFF);
        tick();
        chk_out("f1.idle", IDLE_W, 8'hFF);

        // Two full words, terminate in its own word
        drive(1'b1, 64'h8877665544332211, 1'b0, 3'd0);
        tick();
        tick();
        chk_out("f2.start", START_W, 8'h01);
        tick();
        chk_out("f2.w0", 64'h8877665544332211, 8'h00);
        drive(1'b1, 64'h0123456789ABCDEF, 1'b1, 3'd7);
        tick();
        chk_out("f2.w1", 64'h0123456789ABCDEF, 8'h00);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        chk_out("f2.term", TERM_W, 8'hFF);
        tick();
        chk_out("f2.ifg", IDLE_W, 8'hFF);
        chk("f2.frame_count", {32'd0, fcnt}, {32'd0, EXP_FRAMES});

        // Underrun after the first data word of a 4-word frame
        drive(1'b1, 64'hA0A1A2A3A4A5A6A7, 1'b0, 3'd0);
        tick();
        tick();
        chk_out("u.start", START_W, 8'h01);
        tick();
        chk_out("u.d0", 64'hA0A1A2A3A4A5A6A7, 8'h00);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        tick();
        chk_out("u.err", ERR_W, 8'hFF);
        chk("u.pulse", {63'd0, und}, 64'd1);
        drive(1'b1, 64'hB0B1B2B3B4B5B6B7, 1'b0, 3'd0);
        tick();
        chk_out("u.term", TERM_W, 8'hFF);
        chk("u.pulse_end", {63'd0, und}, 64'd0);
        chk("u.ready_term", {63'd0, bus.tx_ready}, 64'd0);
        tick();
        chk_out("u.ifg", IDLE_W, 8'hFF);
        chk("u.ready_drop", {63'd0, bus.tx_ready}, 64'd1);
        tick();
        chk_out("u.drop1", IDLE_W, 8'hFF);
        drive(1'b1, 64'hD0D1D2D3D4D5D6D7, 1'b1, 3'd5);
        tick();
        chk_out("u.drop2", IDLE_W, 8'hFF);
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        chk("u.ready_idle", {63'd0, bus.tx_ready}, 64'd0);
        chk("u.underrun_count", {32'd0, ucnt}, {32'd0, EXP_UNDERRUNS});
        tick();
        chk_out("u.after", IDLE_W, 8'hFF);

        // Link down gates frame start
        link_up = 1'b0;
        drive(1'b1, 64'h00000000000000AB, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("ld.idle", IDLE_W, 8'hFF);
            chk("ld.ready", {63'd0, bus.tx_ready}, 64'd0);
        end
        link_up = 1'b1;
        tick();
        chk_out("lu.pre", IDLE_W, 8'hFF);
        tick();
        chk_out("lu.start", START_W, 8'h01);
        tick();
        drive(1'b0, 64'd0, 1'b0, 3'd0);
        chk_out("lu.term", 64'h070707070707FDAB, 8'hFE);
        tick();
        chk_out("lu.ifg", IDLE_W, 8'hFF);

        // IFG_WORDS=3, back-to-back one-word frames
        bus3.tx_valid  = 1'b1;
        bus3.tx_data   = 64'h1122334455667788;
        bus3.tx_last   = 1'b1;
        bus3.tx_nbytes = 3'd3;
        tick();
        tick();
        chk_out3("g3.start", START_W, 8'h01);
        tick();
        chk_out3("g3.term", 64'h070707FD55667788, 8'hF0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out3("g3.ifg", IDLE_W, 8'hFF);
            chk("g3.ready", {63'd0, bus3.tx_ready}, 64'd0);
        end
        tick();
        chk_out3("g3.idle", IDLE_W, 8'hFF);
        tick();
        chk_out3("g3.start2", START_W, 8'h01);
        tick();
        bus3.tx_valid = 1'b0;
        chk_out3("g3.term2", 64'h070707FD55667788, 8'hF0);
        tick();
        chk_out3("g3.ifg2", IDLE_W, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
